// File: rtl/cpld_uart_responder.sv
// Stand-in for the CPLD serial controller: answers uart_rdn/uart_wrn strobes on the
// shared bus, with a receive FIFO fed from a byte stream and a timed transmit engine.
module cpld_uart_responder #(
  parameter int DEPTH     = 4,
  parameter int TX_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       err_underflow,
  output logic       err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = (TX_CYCLES > 1) ? $clog2(TX_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_OUT
  } state_t;

  // Strobes pass through one sampling stage before edge detection against the history flop.
  logic          rdn_s_q, rdn_s_d, rdn_q, rdn_d;
  logic          wrn_s_q, wrn_s_d, wrn_q, wrn_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [7:0]    bus_dout_q, bus_dout_d;
  logic          bus_oe_q, bus_oe_d;
  logic          rd_hit_q, rd_hit_d;
  logic          err_underflow_q, err_underflow_d;
  logic          err_overflow_q, err_overflow_d;

  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic [NW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;

  logic          rd_fall, rd_rise, wr_rise;
  logic          push, pop;

  assign rd_fall = rdn_q & ~rdn_s_q;
  assign rd_rise = ~rdn_q & rdn_s_q;
  assign wr_rise = ~wrn_q & wrn_s_q;

  assign rx_ready       = (count_q != CW'(DEPTH));
  assign uart_dataready = (count_q != '0);
  assign push           = rx_valid & rx_ready;
  assign pop            = rd_rise & rd_hit_q;

  assign bus_dout      = bus_dout_q;
  assign bus_oe        = bus_oe_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;
  assign tx_byte       = tx_byte_q;
  assign tx_valid      = tx_valid_q;
  assign uart_tbre     = ~hold_full_q;
  assign uart_tsre     = ~hold_full_q & (state_q == ST_IDLE);

  always_comb begin
    rdn_s_d         = uart_rdn;
    rdn_d           = rdn_s_q;
    wrn_s_d         = uart_wrn;
    wrn_d           = wrn_s_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    bus_dout_d      = bus_dout_q;
    bus_oe_d        = bus_oe_q;
    rd_hit_d        = rd_hit_q;
    err_underflow_d = 1'b0;
    err_overflow_d  = 1'b0;
    wr_data_d       = wr_data_q;
    hold_d          = hold_q;
    hold_full_d     = hold_full_q;
    shift_d         = shift_q;
    cnt_d           = cnt_q;
    state_d         = state_q;
    tx_byte_d       = tx_byte_q;
    tx_valid_d      = tx_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // An empty read still drives the bus (with zero) so the initiator never sees a floating byte.
    if (rd_fall) begin
      bus_oe_d = 1'b1;
      if (count_q != '0) begin
        bus_dout_d = mem_q[rd_ptr_q];
        rd_hit_d   = 1'b1;
      end else begin
        bus_dout_d      = 8'h00;
        rd_hit_d        = 1'b0;
        err_underflow_d = 1'b1;
      end
    end else if (rd_rise) begin
      bus_oe_d = 1'b0;
      rd_hit_d = 1'b0;
    end

    if (!uart_wrn) wr_data_d = bus_din;

    if (wr_rise) begin
      if (!hold_full_q) begin
        hold_d      = wr_data_q;
        hold_full_d = 1'b1;
      end else begin
        err_overflow_d = 1'b1;
      end
    end

    // The shifter only takes from a register that was already full, so it never races a load.
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = NW'(TX_CYCLES - 1);
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          tx_byte_d  = shift_q;
          tx_valid_d = 1'b1;
          state_d    = ST_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OUT: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_s_q         <= 1'b1;
      rdn_q           <= 1'b1;
      wrn_s_q         <= 1'b1;
      wrn_q           <= 1'b1;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      bus_dout_q      <= 8'h00;
      bus_oe_q        <= 1'b0;
      rd_hit_q        <= 1'b0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      wr_data_q       <= 8'h00;
      hold_q          <= 8'h00;
      hold_full_q     <= 1'b0;
      shift_q         <= 8'h00;
      cnt_q           <= '0;
      state_q         <= ST_IDLE;
      tx_byte_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
    end else begin
      rdn_s_q         <= rdn_s_d;
      rdn_q           <= rdn_d;
      wrn_s_q         <= wrn_s_d;
      wrn_q           <= wrn_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      bus_dout_q      <= bus_dout_d;
      bus_oe_q        <= bus_oe_d;
      rd_hit_q        <= rd_hit_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
      wr_data_q       <= wr_data_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      shift_q         <= shift_d;
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      tx_byte_q       <= tx_byte_d;
      tx_valid_q      <= tx_valid_d;
    end
  end

endmodule

// File: tb/tb_cpld_uart_responder.sv
// Directed bench for cpld_uart_responder: bus reads/writes, FIFO limits, transmit timing,
// overflow/underflow pulses and mid-operation reset.
module tb_cpld_uart_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rdn, uart_wrn;
  logic       uart_dataready, uart_tbre, uart_tsre;
  logic [7:0] bus_din, bus_dout;
  logic       bus_oe;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready;
  logic       err_underflow, err_overflow;

  int compared   = 0;
  int mismatched = 0;

  cpld_uart_responder #(.DEPTH(4), .TX_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds uart_rdn low for four sampled edges; optionally pushes a byte on the rise edge.
  task automatic do_read(input bit push_at_rise, input logic [7:0] pbyte,
                         output logic [7:0] dout, output logic oe, output logic unf,
                         output logic unf_next, output logic oe_held, output logic oe_after);
    uart_rdn = 1'b0;
    tick();
    tick();
    dout = bus_dout;
    oe   = bus_oe;
    unf  = err_underflow;
    tick();
    unf_next = err_underflow;
    tick();
    uart_rdn = 1'b1;
    tick();
    oe_held = bus_oe;
    if (push_at_rise) begin
      rx_valid = 1'b1;
      rx_byte  = pbyte;
    end
    tick();
    rx_valid = 1'b0;
    oe_after = bus_oe;
  endtask

  // Returns just after the edge that samples uart_wrn high.
  task automatic do_write(input logic [7:0] b);
    bus_din  = b;
    uart_wrn = 1'b0;
    tick();
    tick();
    uart_wrn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    compared++;
    if ({bus_oe, bus_dout} !== 9'h000) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got %h expected %h", {bus_oe, bus_dout}, 9'h000);
    end
    compared++;
    if ({uart_dataready, uart_tbre, uart_tsre, rx_ready} !== 4'b0111) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got %b expected %b",
               {uart_dataready, uart_tbre, uart_tsre, rx_ready}, 4'b0111);
    end
    compared++;
    if ({tx_valid, tx_byte, err_underflow, err_overflow} !== 11'h000) begin
      mismatched++;
      $display("[TB] FAIL reset_tx_err: got %h expected %h",
               {tx_valid, tx_byte, err_underflow, err_overflow}, 11'h000);
    end
  endtask

  task automatic test_read_basic();
    logic [7:0] d;
    logic oe, unf, unf2, oeh, oea;
    rx_valid = 1'b1;
    rx_byte  = 8'h41;
    tick();
    compared++;
    if (uart_dataready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL push_dataready: got %b expected 1", uart_dataready);
    end
    rx_byte = 8'h42;
    tick();
    rx_valid = 1'b0;
    do_read(1'b0, 8'h00, d, oe, unf, unf2, oeh, oea);
    compared++;
    if ({oe, d, oeh, oea, unf} !== {1'b1, 8'h41, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL read_first: got oe=%b dout=%h held=%b after=%b unf=%b expected 1 41 1 0 0",
               oe, d, oeh, oea, unf);
    end
    compared++;
    if (uart_dataready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_first_ready: got %b expected 1", uart_dataready);
    end
    do_read(1'b0, 8'h00, d, oe, unf, unf2, oeh, oea);
    compared++;
    if ({oe, d, oeh, oea} !== {1'b1, 8'h42, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL read_second: got oe=%b dout=%h held=%b after=%b expected 1 42 1 0",
               oe, d, oeh, oea);
    end
    compared++;
    if (uart_dataready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_drained: got %b expected 0", uart_dataready);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    logic oe, unf, unf2, oeh, oea;
    logic [7:0] rest [3];
    rest[0] = 8'hA3;
    rest[1] = 8'hA4;
    rest[2] = 8'hB6;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte = 8'hA1 + 8'(i);
      tick();
    end
    compared++;
    if (rx_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_rx_ready: got %b expected 0", rx_ready);
    end
    rx_byte = 8'hEE;
    tick();
    rx_valid = 1'b0;
    do_read(1'b0, 8'h00, d, oe, unf, unf2, oeh, oea);
    compared++;
    if ({d, rx_ready} !== {8'hA1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL full_pop: got dout=%h rx_ready=%b expected A1 1", d, rx_ready);
    end
    do_read(1'b1, 8'hB6, d, oe, unf, unf2, oeh, oea);
    compared++;
    if ({d, rx_ready, uart_dataready} !== {8'hA2, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL push_pop_same: got dout=%h rx_ready=%b ready=%b expected A2 1 1",
               d, rx_ready, uart_dataready);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(1'b0, 8'h00, d, oe, unf, unf2, oeh, oea);
      compared++;
      if (d !== rest[i]) begin
        mismatched++;
        $display("[TB] FAIL drain_%0d: got %h expected %h", i, d, rest[i]);
      end
    end
    compared++;
    if (uart_dataready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drain_empty: got %b expected 0", uart_dataready);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] d;
    logic oe, unf, unf2, oeh, oea;
    do_read(1'b0, 8'h00, d, oe, unf, unf2, oeh, oea);
    compared++;
    if ({oe, d, unf, unf2, oea} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL underflow: got oe=%b dout=%h pulse=%b next=%b after=%b expected 1 00 1 0 0",
               oe, d, unf, unf2, oea);
    end
    compared++;
    if ({uart_dataready, rx_ready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL underflow_count: got %b expected 01", {uart_dataready, rx_ready});
    end
  endtask

  task automatic test_tx_single();
    logic early, tsre_hi;
    early   = 1'b0;
    tsre_hi = 1'b0;
    tx_ready = 1'b1;
    do_write(8'h5A);
    tick();
    compared++;
    if ({uart_tbre, uart_tsre} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL tx_hold_loaded: got %b expected 00", {uart_tbre, uart_tsre});
    end
    tick();
    compared++;
    if ({uart_tbre, uart_tsre} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL tx_shift_loaded: got %b expected 10", {uart_tbre, uart_tsre});
    end
    for (int i = 3; i <= 9; i++) begin
      tick();
      if (tx_valid) early = 1'b1;
      if (uart_tsre) tsre_hi = 1'b1;
    end
    compared++;
    if ({early, tsre_hi} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL tx_busy_window: got early=%b tsre=%b expected 0 0", early, tsre_hi);
    end
    tick();
    compared++;
    if ({tx_valid, tx_byte, uart_tsre} !== {1'b1, 8'h5A, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL tx_out: got valid=%b byte=%h tsre=%b expected 1 5A 0",
               tx_valid, tx_byte, uart_tsre);
    end
    tick();
    compared++;
    if ({tx_valid, uart_tsre, uart_tbre} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL tx_accepted: got %b expected 011", {tx_valid, uart_tsre, uart_tbre});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [$];
    int waited;
    tx_ready = 1'b0;
    do_write(8'h11);
    do_write(8'h22);
    do_write(8'h33);
    tick();
    compared++;
    if (err_overflow !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL overflow_pulse: got %b expected 1", err_overflow);
    end
    tick();
    compared++;
    if (err_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL overflow_width: got %b expected 0", err_overflow);
    end
    waited = 0;
    while (!tx_valid && waited < 30) begin
      tick();
      waited++;
    end
    compared++;
    if (tx_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_wait: got tx_valid=%b after %0d cycles expected 1", tx_valid, waited);
    end
    repeat (3) tick();
    compared++;
    if ({tx_valid, tx_byte, uart_tbre} !== {1'b1, 8'h11, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL b2b_stall: got valid=%b byte=%h tbre=%b expected 1 11 0",
               tx_valid, tx_byte, uart_tbre);
    end
    tx_ready = 1'b1;
    repeat (40) begin
      tick();
      if (tx_valid) got.push_back(tx_byte);
    end
    compared++;
    if (got.size() != 1 || got[0] !== 8'h22) begin
      mismatched++;
      $display("[TB] FAIL b2b_stream: got %0d bytes first=%h expected 1 byte 22",
               got.size(), (got.size() > 0) ? got[0] : 8'hXX);
    end
    compared++;
    if ({uart_tbre, uart_tsre} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got %b expected 11", {uart_tbre, uart_tsre});
    end
  endtask

  task automatic test_reset_mid();
    logic leak;
    leak = 1'b0;
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'hC1;
    tick();
    rx_byte = 8'hC2;
    tick();
    rx_valid = 1'b0;
    do_write(8'h77);
    repeat (3) tick();
    compared++;
    if ({uart_tsre, uart_dataready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL mid_busy: got %b expected 01", {uart_tsre, uart_dataready});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if ({bus_oe, bus_dout, uart_dataready, uart_tbre, uart_tsre, rx_ready} !== {9'h000, 4'b0111}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_status: got %h expected %h",
               {bus_oe, bus_dout, uart_dataready, uart_tbre, uart_tsre, rx_ready}, {9'h000, 4'b0111});
    end
    compared++;
    if ({tx_valid, tx_byte, err_underflow, err_overflow} !== 11'h000) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_tx: got %h expected %h",
               {tx_valid, tx_byte, err_underflow, err_overflow}, 11'h000);
    end
    repeat (20) begin
      tick();
      if (tx_valid || uart_dataready || !uart_tsre) leak = 1'b1;
    end
    compared++;
    if (leak !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_leak: got %b expected 0", leak);
    end
  endtask

  initial begin
    rst      = 1'b1;
    uart_rdn = 1'b1;
    uart_wrn = 1'b1;
    bus_din  = 8'h00;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_read_basic();
    test_fifo_full();
    test_underflow();
    test_tx_single();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
